xout_window_acc: RTL and testbench

//   Downstream stage of the ExtraArgs multiply/offset datapath: consumes its
//   8-bit XOUT result stream and reduces fixed-length windows of samples to
//   SUM/MIN/MAX statistics.

---
 rtl/xout_window_acc.sv | 115 +++++++++++
 tb/tb_xout_window_acc.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xout_window_acc.sv
// xout_window_acc
//   Reduces the 8-bit XOUT sample stream into fixed-length windows and emits
//   SUM / MIN / MAX / COUNT for each completed window. A FLUSH closes a
//   partial window early. Both sides use a valid/ready handshake.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous reset, active-high
//   xout       unsigned input sample (NX bits)
//   in_valid   sample valid
//   in_ready   stage can accept a sample (registered)
//   flush      close the current partial window (level, sampled per cycle)
//   sum        sum of window samples (NA bits, cannot overflow)
//   omin       minimum sample of window
//   omax       maximum sample of window
//   cnt        number of samples in the emitted window
//   out_valid  result valid (registered)
//   out_ready  consumer accepts result
module xout_window_acc #(
  parameter  int NX       = 8,
  parameter  int NSAMPLES = 4,
  localparam int NS       = $clog2(NSAMPLES + 1),
  localparam int NA       = NX + $clog2(NSAMPLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NX-1:0] xout,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic [NA-1:0] sum,
  output logic [NX-1:0] omin,
  output logic [NX-1:0] omax,
  output logic [NS-1:0] cnt,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic {ACCUM = 1'b0, EMIT = 1'b1} state_t;

  state_t        state;
  logic [NA-1:0] acc, acc_nx;
  logic [NX-1:0] mn, mx, mn_nx, mx_nx;
  logic [NS-1:0] n, n_nx;
  logic          hs, close;

  // Accumulator values including this cycle's sample, so a closing window
  // reports the sample that closed it.
  always_comb begin
    hs     = in_valid & in_ready;
    acc_nx = acc;
    mn_nx  = mn;
    mx_nx  = mx;
    n_nx   = n;
    if (hs) begin
      acc_nx = acc + NA'(xout);
      if (xout < mn) mn_nx = xout;
      if (xout > mx) mx_nx = xout;
      n_nx   = n + NS'(1);
    end
    // An idle flush on an empty window produces nothing.
    close = (state == ACCUM) &&
            ((hs && (n_nx == NS'(NSAMPLES))) || (flush && ((n != '0) || hs)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      mn        <= '1;
      mx        <= '0;
      n         <= '0;
      sum       <= '0;
      omin      <= '0;
      omax      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (close) begin
            sum       <= acc_nx;
            omin      <= mn_nx;
            omax      <= mx_nx;
            cnt       <= n_nx;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            state     <= EMIT;
            acc       <= '0;
            mn        <= '1;
            mx        <= '0;
            n         <= '0;
          end else begin
            in_ready  <= 1'b1;
            acc       <= acc_nx;
            mn        <= mn_nx;
            mx        <= mx_nx;
            n         <= n_nx;
          end
        end
        EMIT: begin
          // Result registers hold until the consumer takes them.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_xout_window_acc.sv
module tb_xout_window_acc;
  localparam int NX       = 8;
  localparam int NSAMPLES = 4;
  localparam int NS       = 3;
  localparam int NA       = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NX-1:0] xout = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic [NA-1:0] sum;
  logic [NX-1:0] omin, omax;
  logic [NS-1:0] cnt;
  logic          out_valid;
  logic          out_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  xout_window_acc #(.NX(NX), .NSAMPLES(NSAMPLES)) dut (
    .clk(clk), .rst(rst), .xout(xout), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .sum(sum), .omin(omin), .omax(omax), .cnt(cnt),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural model: window held as a list of accepted samples; stats are
  // computed from the list when the window closes.
  int win[$];
  bit m_init = 0, m_pend = 0, m_rdy = 0;
  int m_sum = 0, m_min = 0, m_max = 0, m_cnt = 0;

  always @(posedge clk) begin
    bit took;
    if (rst) begin
      win.delete();
      m_init = 1; m_pend = 0; m_rdy = 0;
      m_sum = 0; m_min = 0; m_max = 0; m_cnt = 0;
    end else if (m_pend) begin
      if (out_ready) begin
        m_pend = 0;
        m_rdy  = 1;
      end
    end else begin
      took = in_valid && m_rdy;
      if (took) win.push_back(int'(xout));
      if ((took && win.size() == NSAMPLES) || (flush && win.size() > 0)) begin
        m_sum = 0; m_min = 255; m_max = 0;
        foreach (win[i]) begin
          m_sum += win[i];
          if (win[i] < m_min) m_min = win[i];
          if (win[i] > m_max) m_max = win[i];
        end
        m_cnt  = win.size();
        win.delete();
        m_pend = 1;
        m_rdy  = 0;
      end else begin
        m_rdy = 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready",  int'(in_ready),  int'(m_rdy));
      chk("out_valid", int'(out_valid), int'(m_pend));
      chk("sum",  int'(sum),  m_sum);
      chk("omin", int'(omin), m_min);
      chk("omax", int'(omax), m_max);
      chk("cnt",  int'(cnt),  m_cnt);
    end
  end

  // Offer one sample (optionally with flush); returns just after the
  // accepting edge.
  task automatic send(input int x, input bit f = 1'b0);
    bit ok = 1'b0;
    in_valid = 1'b1;
    xout     = NX'(x);
    flush    = f;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout got=0 want=1 sample=%0d", x);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic pulse_flush();
    in_valid = 1'b0;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
  endtask

  // Wait for a result and compare against hand-computed literals.
  task automatic check_res(input int s, input int mn, input int mx, input int c);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        chk("lit_sum",  int'(sum),  s);
        chk("lit_omin", int'(omin), mn);
        chk("lit_omax", int'(omax), mx);
        chk("lit_cnt",  int'(cnt),  c);
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL result_timeout got=0 want=1 sum=%0d", s);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_sum", int'(sum), 0);
    chk("rst_omin", int'(omin), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // 1. Basic window, valid held high
    send(10); send(20); send(30); send(40);
    idle();
    check_res(100, 10, 40, 4);

    // 2. Extremes
    send(255); send(255); send(255); send(255);
    idle();
    check_res(1020, 255, 255, 4);
    send(0); send(0); send(0); send(0);
    idle();
    check_res(0, 0, 0, 4);

    // 3. Backpressure, with a sample offered during the stall
    out_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    in_valid = 1'b1;
    xout     = 8'd50;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_sum", int'(sum), 10);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    idle();
    pulse_flush();
    check_res(50, 50, 50, 1);

    // 4. Flush cases
    send(5); send(7);
    idle();
    pulse_flush();
    check_res(12, 5, 7, 2);
    send(9, 1'b1);
    idle();
    check_res(9, 9, 9, 1);
    pulse_flush();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("empty_flush_out_valid", int'(out_valid), 0);
    end
    @(posedge clk); #1;

    // 5. Reset mid-window
    send(100); send(101); send(102);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midwin_rst_sum", int'(sum), 0);
    chk("midwin_rst_cnt", int'(cnt), 0);
    chk("midwin_rst_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    send(2); send(2); send(2); send(2);
    idle();
    check_res(8, 2, 2, 4);

    // Reset during EMIT
    out_ready = 1'b0;
    send(1); send(1); send(1); send(1);
    idle();
    @(negedge clk);
    chk("pre_rst_out_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("emit_rst_out_valid", int'(out_valid), 0);
    chk("emit_rst_sum", int'(sum), 0);
    @(posedge clk); #1;
    send(3); send(1); send(4); send(1);
    idle();
    check_res(9, 1, 4, 4);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 want=0");
    $fatal(1, "timeout");
  end

endmodule
